spi_reg_bank: RTL

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank_if.sv | 24 ++
 rtl/spi_reg_bank.sv | 132 +++++++++++++
 2 files changed

// File: rtl/spi_reg_bank_if.sv
// Strobed register-access bus between an SPI slave front end and spi_reg_bank.
interface spi_reg_bank_if;
    logic        reg_read_stb;
    logic        reg_write_stb;
    logic [6:0]  spi_addr;
    logic [15:0] spi_write_data;
    logic [15:0] spi_read_data;

    modport master (
        output reg_read_stb,
        output reg_write_stb,
        output spi_addr,
        output spi_write_data,
        input  spi_read_data
    );

    modport slave (
        input  reg_read_stb,
        input  reg_write_stb,
        input  spi_addr,
        input  spi_write_data,
        output spi_read_data
    );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI-addressed control/status register bank with sticky events, IRQ,
// error counter and an auto-incrementing coefficient RAM port.
module spi_reg_bank #(
    parameter logic [15:0] ID_VALUE = 16'hA0D1,
    parameter int          COEF_AW  = 10,
    parameter int          NUM_EVT  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_reg_bank_if.slave      bus,
    output logic [15:0]        ctrl,
    input  logic [NUM_EVT-1:0] status_live,
    input  logic [NUM_EVT-1:0] status_event,
    output logic               irq,
    output logic [COEF_AW-1:0] coef_addr,
    output logic [15:0]        coef_wdata,
    output logic               coef_wr_stb,
    input  logic [15:0]        coef_rd_data
);

    localparam logic [6:0] ADDR_ID        = 7'h00;
    localparam logic [6:0] ADDR_CTRL      = 7'h01;
    localparam logic [6:0] ADDR_STATUS    = 7'h02;
    localparam logic [6:0] ADDR_IRQ_MASK  = 7'h03;
    localparam logic [6:0] ADDR_SCRATCH   = 7'h04;
    localparam logic [6:0] ADDR_ERR_CNT   = 7'h05;
    localparam logic [6:0] ADDR_COEF_PTR  = 7'h08;
    localparam logic [6:0] ADDR_COEF_DATA = 7'h09;

    localparam logic [COEF_AW-1:0] PTR_ONE = {{(COEF_AW-1){1'b0}}, 1'b1};

    logic [15:0]          ctrl_reg;
    logic [NUM_EVT-1:0]   irq_mask;
    logic [15:0]          scratch;
    logic [NUM_EVT-1:0]   sticky;
    logic [15:0]          err_cnt;
    logic [COEF_AW-1:0]   ptr;
    logic [15:0]          wdata_reg;
    logic                 wr_pulse;
    logic                 inc_pending;
    logic                 irq_reg;
    logic [15:0]          read_reg;

    logic                 wr;
    logic                 rd;
    logic [6:0]           addr;
    logic [15:0]          wdata;
    logic [2*NUM_EVT-1:0] status_word;
    logic [NUM_EVT-1:0]   clear_mask;
    logic [15:0]          read_value;

    assign wr          = bus.reg_write_stb;
    assign rd          = bus.reg_read_stb;
    assign addr        = bus.spi_addr;
    assign wdata       = bus.spi_write_data;
    assign status_word = {status_live, sticky};
    assign clear_mask  = (wr && addr == ADDR_STATUS) ? wdata[NUM_EVT-1:0] : '0;

    always_comb begin
        read_value = 16'h0000;
        case (addr)
            ADDR_ID:        read_value = ID_VALUE;
            ADDR_CTRL:      read_value = ctrl_reg;
            ADDR_STATUS:    read_value = 16'(status_word);
            ADDR_IRQ_MASK:  read_value = 16'(irq_mask);
            ADDR_SCRATCH:   read_value = scratch;
            ADDR_ERR_CNT:   read_value = err_cnt;
            ADDR_COEF_PTR:  read_value = 16'(ptr);
            ADDR_COEF_DATA: read_value = coef_rd_data;
            default:        read_value = 16'h0000;
        endcase
    end

    // Reads capture the pre-write value because the mux sees the old registers.
    // A COEF_PTR write issued alongside a pending increment overrides it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_reg    <= '0;
            irq_mask    <= '0;
            scratch     <= '0;
            sticky      <= '0;
            err_cnt     <= '0;
            ptr         <= '0;
            wdata_reg   <= '0;
            wr_pulse    <= 1'b0;
            inc_pending <= 1'b0;
            irq_reg     <= 1'b0;
            read_reg    <= '0;
        end else begin
            wr_pulse    <= 1'b0;
            inc_pending <= 1'b0;
            if (inc_pending)
                ptr <= ptr + PTR_ONE;
            sticky  <= (sticky & ~clear_mask) | status_event;
            irq_reg <= |(sticky & irq_mask);
            if (rd) begin
                read_reg <= read_value;
                if (addr == ADDR_COEF_DATA)
                    inc_pending <= 1'b1;
            end
            if (wr) begin
                case (addr)
                    ADDR_CTRL:      ctrl_reg <= wdata;
                    ADDR_STATUS:    begin end
                    ADDR_IRQ_MASK:  irq_mask <= wdata[NUM_EVT-1:0];
                    ADDR_SCRATCH:   scratch  <= wdata;
                    ADDR_ERR_CNT:   err_cnt  <= '0;
                    ADDR_COEF_PTR:  ptr      <= wdata[COEF_AW-1:0];
                    ADDR_COEF_DATA: begin
                        wdata_reg   <= wdata;
                        wr_pulse    <= 1'b1;
                        inc_pending <= 1'b1;
                    end
                    default: begin
                        if (err_cnt != 16'hFFFF)
                            err_cnt <= err_cnt + 16'd1;
                    end
                endcase
            end
        end
    end

    // Outputs are forced low for as long as reset_n is held, so a RAM write
    // strobe issued just before reset never reaches the RAM.
    assign ctrl              = reset_n ? ctrl_reg  : '0;
    assign irq               = reset_n ? irq_reg   : 1'b0;
    assign coef_addr         = reset_n ? ptr       : '0;
    assign coef_wdata        = reset_n ? wdata_reg : '0;
    assign coef_wr_stb       = reset_n ? wr_pulse  : 1'b0;
    assign bus.spi_read_data = reset_n ? read_reg  : '0;

endmodule
